// File: rtl/reg_bench_mp.sv
// Multi-read-port register bench with a link write port and a per-register busy scoreboard.
// Define REG_BENCH_BYPASS_EN to forward same-cycle write data onto matching read ports.
module reg_bench_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int N_RD     = 2,
  parameter int LINK_REG = 31
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  input  logic [N_RD-1:0]          rd_use,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic [N_RD-1:0]          rd_busy,
  output logic                     stall,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     lnk_en,
  input  logic [DATA_W-1:0]        lnk_data,
  input  logic                     resv_en,
  input  logic [ADDR_W-1:0]        resv_addr
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  busy_reg;

  logic wr_act;
  logic lnk_act;
  logic resv_act;

  assign wr_act   = wr_en && (wr_addr != '0);
  // A write-back to the link register is the younger result, so it shadows the link write.
  assign lnk_act  = lnk_en && (LINK_IDX != '0) && !(wr_act && (wr_addr == LINK_IDX));
  assign resv_act = resv_en && (resv_addr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_reg[k] <= '0;
      end
      busy_reg <= '0;
    end else begin
      if (lnk_act) begin
        mem_reg[LINK_IDX]  <= lnk_data;
        busy_reg[LINK_IDX] <= 1'b0;
      end
      if (wr_act) begin
        mem_reg[wr_addr]  <= wr_data;
        busy_reg[wr_addr] <= 1'b0;
      end
      // Reservation comes last: it belongs to the newer instruction and must win the busy bit.
      if (resv_act) begin
        busy_reg[resv_addr] <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              busy;

      assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        data = mem_reg[addr];
        busy = busy_reg[addr];
`ifdef REG_BENCH_BYPASS_EN
        if (addr != '0) begin
          if (wr_act && (wr_addr == addr)) begin
            data = wr_data;
            busy = resv_act && (resv_addr == addr);
          end else if (lnk_act && (LINK_IDX == addr)) begin
            data = lnk_data;
            busy = resv_act && (resv_addr == addr);
          end
        end
`endif
        if (reset || (addr == '0)) begin
          data = '0;
          busy = 1'b0;
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = data;
      assign rd_busy[gi]                  = busy;
    end
  endgenerate

  assign stall = |(rd_use & rd_busy);

endmodule

// File: tb/tb_reg_bench_mp.sv
// Scoreboard bench for reg_bench_mp: a default 32x64/2-port instance driven against a reference
// model, plus a 16x16/3-port instance checked against directly computed values.
module tb_reg_bench_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        a_reset;
  logic [5:0]  a_addr0, a_addr1;
  logic [1:0]  a_use;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_stall;
  logic        a_wr_en;
  logic [5:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        a_lnk_en;
  logic [31:0] a_lnk_data;
  logic        a_resv_en;
  logic [5:0]  a_resv_addr;

  reg_bench_mp dut_a (
    .clk       (clk),
    .reset     (a_reset),
    .rd_addr   ({a_addr1, a_addr0}),
    .rd_use    (a_use),
    .rd_data   (a_rd_data),
    .rd_busy   (a_rd_busy),
    .stall     (a_stall),
    .wr_en     (a_wr_en),
    .wr_addr   (a_wr_addr),
    .wr_data   (a_wr_data),
    .lnk_en    (a_lnk_en),
    .lnk_data  (a_lnk_data),
    .resv_en   (a_resv_en),
    .resv_addr (a_resv_addr)
  );

  // Instance B: 16-bit data, 16 registers, 3 read ports
  logic        b_reset;
  logic [11:0] b_rd_addr;
  logic [2:0]  b_use;
  logic [47:0] b_rd_data;
  logic [2:0]  b_rd_busy;
  logic        b_stall;
  logic        b_wr_en;
  logic [3:0]  b_wr_addr;
  logic [15:0] b_wr_data;
  logic        b_lnk_en;
  logic [15:0] b_lnk_data;
  logic        b_resv_en;
  logic [3:0]  b_resv_addr;

  reg_bench_mp #(.DATA_W(16), .ADDR_W(4), .N_RD(3), .LINK_REG(15)) dut_b (
    .clk       (clk),
    .reset     (b_reset),
    .rd_addr   (b_rd_addr),
    .rd_use    (b_use),
    .rd_data   (b_rd_data),
    .rd_busy   (b_rd_busy),
    .stall     (b_stall),
    .wr_en     (b_wr_en),
    .wr_addr   (b_wr_addr),
    .wr_data   (b_wr_data),
    .lnk_en    (b_lnk_en),
    .lnk_data  (b_lnk_data),
    .resv_en   (b_resv_en),
    .resv_addr (b_resv_addr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          sel;
    string       tag;
    logic [63:0] val;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] ma_mem  [64];
  logic        ma_busy [64];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic push(input int sel, input string tag, input logic [63:0] val);
    exp_t e;
    e.sel = sel;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      0:       return 64'(a_rd_data[31:0]);
      1:       return 64'(a_rd_data[63:32]);
      2:       return 64'(a_rd_busy);
      3:       return 64'(a_stall);
      10:      return 64'(b_rd_data[15:0]);
      11:      return 64'(b_rd_data[31:16]);
      12:      return 64'(b_rd_data[47:32]);
      13:      return 64'(b_rd_busy);
      default: return 64'(b_stall);
    endcase
  endfunction

  // Expected combinational read of one A port from the model and the current inputs
  task automatic model_read(input logic [5:0] ad, output logic [31:0] d, output logic b);
    logic wr_hit;
    d = ma_mem[ad];
    b = ma_busy[ad];
    wr_hit = a_wr_en && (a_wr_addr == ad);
`ifdef REG_BENCH_BYPASS_EN
    if (wr_hit) begin
      d = a_wr_data;
      b = a_resv_en && (a_resv_addr == ad);
    end else if (a_lnk_en && (ad == 6'd31)) begin
      d = a_lnk_data;
      b = a_resv_en && (a_resv_addr == ad);
    end
`endif
    if (a_reset || (ad == 6'd0)) begin
      d = '0;
      b = 1'b0;
    end
  endtask

  task automatic model_update();
    if (a_reset) begin
      for (int k = 0; k < 64; k++) begin
        ma_mem[k]  = '0;
        ma_busy[k] = 1'b0;
      end
    end else begin
      if (a_lnk_en && !(a_wr_en && (a_wr_addr == 6'd31))) begin
        ma_mem[31]  = a_lnk_data;
        ma_busy[31] = 1'b0;
      end
      if (a_wr_en && (a_wr_addr != 6'd0)) begin
        ma_mem[a_wr_addr]  = a_wr_data;
        ma_busy[a_wr_addr] = 1'b0;
      end
      if (a_resv_en && (a_resv_addr != 6'd0)) ma_busy[a_resv_addr] = 1'b1;
    end
  endtask

  // One clock: push model expectations, compare the whole queue mid-cycle, advance the model.
  task automatic tick();
    logic [31:0] d0, d1;
    logic        b0, b1;
    exp_t        e;
    model_read(a_addr0, d0, b0);
    model_read(a_addr1, d1, b1);
    push(0, "a_rd0", 64'(d0));
    push(1, "a_rd1", 64'(d1));
    push(2, "a_busy", 64'({b1, b0}));
    push(3, "a_stall", 64'(|(a_use & {b1, b0})));
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val(e.tag, observe(e.sel), e.val);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic a_idle();
    a_wr_en   = 1'b0;
    a_lnk_en  = 1'b0;
    a_resv_en = 1'b0;
  endtask

  function automatic logic [15:0] bval(input int k);
    return 16'h1000 + 16'(k) * 16'h0111;
  endfunction

  function automatic logic [5:0] rand_addr();
    int v;
    v = $urandom_range(0, 8);
    return (v == 8) ? 6'd31 : 6'(v);
  endfunction

  initial begin
    a_reset = 1'b1; a_addr0 = '0; a_addr1 = '0; a_use = '0;
    a_wr_addr = '0; a_wr_data = '0; a_lnk_data = '0; a_resv_addr = '0;
    a_idle();
    b_reset = 1'b1; b_rd_addr = '0; b_use = '0; b_wr_en = 1'b0; b_wr_addr = '0;
    b_wr_data = '0; b_lnk_en = 1'b0; b_lnk_data = '0; b_resv_en = 1'b0; b_resv_addr = '0;
    for (int k = 0; k < 64; k++) begin
      ma_mem[k]  = 'x;
      ma_busy[k] = 1'bx;
    end
    @(posedge clk); #1;
    push(0, "rst_rd0", 0); push(2, "rst_busy", 0); push(3, "rst_stall", 0);
    tick();
    a_reset = 1'b0; b_reset = 1'b0;

    // Reset clears data and pending reservations, and discards same-cycle writes
    a_wr_en = 1; a_wr_addr = 5; a_wr_data = 32'hDEADBEEF; a_resv_en = 1; a_resv_addr = 6;
    tick();
    a_idle(); a_addr0 = 5; a_addr1 = 6; a_use = 2'b10;
    push(0, "pre_rst_r5", 32'hDEADBEEF); push(2, "pre_rst_busy", 2'b10); push(3, "pre_rst_stall", 1);
    tick();
    a_reset = 1; a_wr_en = 1; a_wr_addr = 5; a_wr_data = 32'h1111; a_lnk_en = 1; a_lnk_data = 32'h77;
    a_resv_en = 1; a_resv_addr = 7; a_use = 2'b11;
    push(0, "in_rst_rd0", 0); push(2, "in_rst_busy", 0); push(3, "in_rst_stall", 0);
    tick();
    a_reset = 0; a_idle(); a_addr1 = 7;
    push(0, "post_rst_r5", 0); push(1, "post_rst_r7", 0); push(2, "post_rst_busy", 0);
    push(3, "post_rst_stall", 0);
    tick();

    // Write then read; writes to r0 are ignored
    a_use = 0; a_wr_en = 1; a_wr_addr = 3; a_wr_data = 5; a_addr0 = 3; a_addr1 = 0;
    tick();
    a_wr_addr = 0; a_wr_data = 7;
    push(0, "r3_rd", 5); push(1, "r0_rd", 0);
    tick();
    a_idle();
    push(1, "r0_after_wr", 0);
    tick();

    // Busy scoreboard and stall
    a_resv_en = 1; a_resv_addr = 4;
    tick();
    a_idle(); a_addr0 = 4; a_use = 2'b01;
    push(3, "stall_resv", 1);
    tick();
    a_wr_en = 1; a_wr_addr = 4; a_wr_data = 32'h1234;
    tick();
    a_idle();
    push(3, "stall_cleared", 0); push(0, "r4_rd", 32'h1234);
    tick();
    a_wr_en = 1; a_wr_addr = 4; a_wr_data = 32'h5678; a_resv_en = 1; a_resv_addr = 4;
    tick();
    a_wr_en = 0;
    push(2, "resv_wins_busy", 2'b01); push(0, "resv_wr_data", 32'h5678); push(3, "resv_wr_stall", 1);
    tick();
    a_idle(); a_wr_en = 1; a_wr_addr = 4; a_wr_data = 32'h9;
    tick();

    // Link port collision and lone link write
    a_idle(); a_use = 0;
    a_wr_en = 1; a_wr_addr = 31; a_wr_data = 9; a_lnk_en = 1; a_lnk_data = 32'h40;
    tick();
    a_idle(); a_addr0 = 31;
    push(0, "link_collide", 9);
    tick();
    a_lnk_en = 1; a_lnk_data = 32'h40;
    tick();
    a_idle();
    push(0, "link_alone", 32'h40);
    tick();

    // Same-cycle write and read of one index
    a_wr_en = 1; a_wr_addr = 7; a_wr_data = 32'hA5; a_addr0 = 7;
`ifdef REG_BENCH_BYPASS_EN
    push(0, "bypass_same_cycle", 32'hA5);
`else
    push(0, "bypass_same_cycle", 0);
`endif
    tick();
    a_idle();
    push(0, "bypass_next_cycle", 32'hA5);
    tick();

    // Randomised traffic over a small index set to force collisions
    for (int n = 0; n < 300; n++) begin
      a_reset     = ($urandom_range(0, 49) == 0);
      a_addr0     = rand_addr();
      a_addr1     = rand_addr();
      a_use       = 2'($urandom_range(0, 3));
      a_wr_en     = 1'($urandom_range(0, 1));
      a_wr_addr   = rand_addr();
      a_wr_data   = $urandom;
      a_lnk_en    = ($urandom_range(0, 3) == 0);
      a_lnk_data  = $urandom;
      a_resv_en   = ($urandom_range(0, 2) == 0);
      a_resv_addr = rand_addr();
      tick();
    end
    a_reset = 0; a_idle(); a_use = 0;

    // Narrow three-port instance: fill r1..r15, then read back on every port
    for (int k = 1; k < 16; k++) begin
      b_wr_en = 1; b_wr_addr = 4'(k); b_wr_data = bval(k); b_rd_addr = '0;
      push(10, "b_r0_p0", 0); push(12, "b_r0_p2", 0);
      tick();
    end
    b_wr_en = 0;
    for (int k = 1; k < 16; k++) begin
      int k1, k2;
      k1 = (k % 15) + 1;
      k2 = ((k + 1) % 15) + 1;
      b_rd_addr = {4'(k2), 4'(k1), 4'(k)};
      push(10, $sformatf("b_p0_r%0d", k), 64'(bval(k)));
      push(11, $sformatf("b_p1_r%0d", k1), 64'(bval(k1)));
      push(12, $sformatf("b_p2_r%0d", k2), 64'(bval(k2)));
      push(13, "b_busy_none", 0);
      tick();
    end
    b_resv_en = 1; b_resv_addr = 5;
    tick();
    b_resv_en = 0; b_rd_addr = {4'd5, 4'd2, 4'd1}; b_use = 3'b011;
    push(13, "b_busy_p2", 3'b100); push(14, "b_stall_unused", 0); push(12, "b_r5_data", 64'(bval(5)));
    tick();
    b_use = 3'b100;
    push(14, "b_stall_used", 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bench_mp.md
# reg_bench_mp

Parametrised multi-read-port register bench for the processor datapath: the next generation of the 2-read / 1-write register bench. It adds configurable data width, depth and read-port count, a dedicated link-register write port, and a per-register busy scoreboard that tracks in-flight loads and produces a stall request. It sits between the controlleur/decode stage (addresses, reservations) and the ALU/memory stage (operands, write-back).

## Interface

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 6, register index width; depth = 2**ADDR_W
- N_RD, 2, number of read ports (1..4)
- LINK_REG, 31, index written by the link port

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on clk rising edge
- rd_addr  in  N_RD*ADDR_W  read indices; port i at bits [i*ADDR_W +: ADDR_W]
- rd_use  in  N_RD  port i operand is consumed this cycle
- rd_data  out  N_RD*DATA_W  read operands; port i at bits [i*DATA_W +: DATA_W]
- rd_busy  out  N_RD  port i source is reserved, value not yet valid
- stall  out  1  OR over i of (rd_use[i] & rd_busy[i])
- wr_en  in  1  write-back enable
- wr_addr  in  ADDR_W  write-back index
- wr_data  in  DATA_W  write-back value
- lnk_en  in  1  link write enable (jump-and-link)
- lnk_data  in  DATA_W  return address written to LINK_REG
- resv_en  in  1  reserve a destination (load issued, result later)
- resv_addr  in  ADDR_W  index to mark busy

## Operation

- Storage: 2**ADDR_W x DATA_W array plus 2**ADDR_W busy bits.
- Register 0: always reads 0, never busy; writes and reservations to index 0 are ignored.
- Reads are combinational from the array and busy bits (with the bypass override below).
- Write-back: wr_en=1 and wr_addr!=0 -> array[wr_addr] <= wr_data; busy[wr_addr] <= 0.
- Link: lnk_en=1 -> array[LINK_REG] <= lnk_data; busy[LINK_REG] <= 0.
- Same-cycle wr_en and lnk_en with wr_addr==LINK_REG: the wr port wins and lnk_data is dropped.
- Reservation: resv_en=1 and resv_addr!=0 -> busy[resv_addr] <= 1.
- Reservation and write to the same index in the same cycle: busy ends at 1 (reservation is the newer instruction); the data is still written.
- Reservation of an already busy index: stays busy; no counting (single outstanding load per register).
- stall is purely combinational; the block never blocks writes on its own stall.

## Timing

- Read latency 0: rd_data/rd_busy follow rd_addr in the same cycle.
- Write latency 1: data is visible on a read of the same index in the cycle after wr_en, or in the same cycle when bypass is compiled in.
- Reset (cycle with reset=1): all registers <= 0, all busy <= 0. During and after that cycle rd_data=0, rd_busy=0, stall=0. Any wr_en, lnk_en or resv_en in the reset cycle is discarded; reset mid-reservation clears the pending busy.
- Reset dominates every other input.

## Configuration

- REG_BENCH_BYPASS_EN defined: a read port whose rd_addr matches an active write this cycle (wr port, else link port) returns that write's data. Its rd_busy is 0 unless resv_en targets the same index in the same cycle. Index 0 is never bypassed.
- Not defined: reads return the stored array value and stored busy bit; a same-cycle write is seen one cycle later. The comparators are not synthesised.

## Test plan

- Reset: write 0xDEADBEEF to r5, assert reset one cycle -> reading r5 gives 0, rd_busy=0, stall=0.
- Write/read: wr r3=5, next cycle read port0=r3, port1=r0 -> rd_data 5 and 0. A write of 7 to r0 -> r0 still reads 0.
- Scoreboard: resv r4, next cycle rd_use[0]=1 with rd_addr0=r4 -> stall=1. Then wr r4=0x1234 -> the cycle after, stall=0 and the data reads 0x1234. Same-cycle resv r4 plus wr r4 -> busy stays 1.
- Link collision: lnk_en with lnk_data=0x40 and wr r31=9 in the same cycle -> r31 reads 9. A lone lnk_en writing 0x40 -> r31 reads 0x40.
- Bypass: wr r7=0xA5 with rd_addr0=r7 in the same cycle -> 0xA5 with REG_BENCH_BYPASS_EN, the old value without it.
- Parametrisation: build DATA_W=16, ADDR_W=4, N_RD=3 and write distinct values to r1..r15 -> all three ports read back correctly; a port with rd_use=0 on a busy register gives stall=0.
